// File: rtl/piso_if.sv
// Handshake and serial-output bundle for the piso block.
interface piso_if #(
  parameter int N = 4
);
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] parallel_in;
  logic         serial_out;
  logic         serial_valid;
  logic         last;
  logic         done;

  // Upstream producer / serial consumer side.
  modport master (
    output load_valid,
    output parallel_in,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  last,
    input  done
  );

  // The piso itself.
  modport slave (
    input  load_valid,
    input  parallel_in,
    output load_ready,
    output serial_out,
    output serial_valid,
    output last,
    output done
  );
endinterface

// File: rtl/piso.sv
// Parallel-in serial-out shift register with valid/ready load and framing flags.
//
// state | meaning
// IDLE  | no word in flight, ready to accept
// SHIFT | emitting one bit per clock; count = index of bit currently on serial_out
module piso #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  piso_if.slave  bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic [CW-1:0] count;
  logic          done_q;
  logic          at_last;
  logic          accept;

  assign at_last        = (state == SHIFT) && (count == LAST_CNT);
  assign bus.load_ready = (state == IDLE) || at_last;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.serial_valid = (state == SHIFT);
  assign bus.serial_out   = (state == SHIFT) && (MSB_FIRST ? shreg[N-1] : shreg[0]);
  assign bus.last         = at_last;
  assign bus.done         = done_q;

  // Load, shift and frame-end sequencing; a reload on the final-bit edge keeps the stream gapless.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.parallel_in;
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            if (accept) begin
              shreg <= bus.parallel_in;
              count <= '0;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else begin
            shreg <= MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso.sv
// Directed self-checking bench for piso: MSB-first and LSB-first instances share clk/reset.
module tb_piso;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  piso_if #(.N(4)) if_a ();
  piso_if #(.N(4)) if_b ();

  piso #(.N(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  piso #(.N(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  // Observation vectors: {serial_valid, serial_out, last, load_ready, done}
  logic [4:0] obs_a, obs_b;
  assign obs_a = {if_a.serial_valid, if_a.serial_out, if_a.last, if_a.load_ready, if_a.done};
  assign obs_b = {if_b.serial_valid, if_b.serial_out, if_b.last, if_b.load_ready, if_b.done};

  // Reference receiver for loopback: shifts serial_in into bit 0 toward the MSB,
  // so an MSB-first word lands in its original bit order after N edges.
  logic [3:0] sipo_q;
  always_ff @(posedge clk) begin
    if (reset) sipo_q <= '0;
    else       sipo_q <= {sipo_q[2:0], if_a.serial_out};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL reset_a: got %b want %b", obs_a, 5'b00010);
    end
    checks++;
    if (obs_b !== 5'b00010) begin
      errors++;
      $display("FAIL reset_b: got %b want %b", obs_b, 5'b00010);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] seq;
    logic [4:0] exp;
    seq = 4'b1011;  // expected bit stream in time order, left to right
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1011;
    tick();
    if_a.load_valid  = 1'b0;
    if_a.parallel_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, seq[3-i], (i == 3), (i == 3), 1'b0};
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL msb_first bit%0d: got %b want %b", i, obs_a, exp);
      end
      tick();
    end
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL msb_first done: got %b want %b", obs_a, 5'b00011);
    end
    tick();
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL msb_first idle: got %b want %b", obs_a, 5'b00010);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] seq;
    logic [4:0] exp;
    seq = 4'b1101;
    if_b.load_valid  = 1'b1;
    if_b.parallel_in = 4'b1011;
    tick();
    if_b.load_valid  = 1'b0;
    if_b.parallel_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, seq[3-i], (i == 3), (i == 3), 1'b0};
      checks++;
      if (obs_b !== exp) begin
        errors++;
        $display("FAIL lsb_first bit%0d: got %b want %b", i, obs_b, exp);
      end
      tick();
    end
    checks++;
    if (obs_b !== 5'b00011) begin
      errors++;
      $display("FAIL lsb_first done: got %b want %b", obs_b, 5'b00011);
    end
    tick();
    checks++;
    if (obs_b !== 5'b00010) begin
      errors++;
      $display("FAIL lsb_first idle: got %b want %b", obs_b, 5'b00010);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [4:0] exp;
    seq = 8'b1011_0110;
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1011;
    tick();
    if_a.parallel_in = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      exp = {1'b1, seq[7-i], (i == 3 || i == 7), (i == 3 || i == 7), 1'b0};
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL back_to_back bit%0d: got %b want %b", i, obs_a, exp);
      end
      tick();
      if (i == 3) begin
        if_a.load_valid  = 1'b0;
        if_a.parallel_in = 4'b1111;
      end
    end
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL back_to_back done: got %b want %b", obs_a, 5'b00011);
    end
    tick();
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL back_to_back idle: got %b want %b", obs_a, 5'b00010);
    end
  endtask

  task automatic test_busy_load();
    logic [3:0] seq;
    logic [4:0] exp;
    seq = 4'b1100;
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1100;
    tick();
    if_a.load_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, seq[3-i], (i == 3), (i == 3), 1'b0};
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL busy_load bit%0d: got %b want %b", i, obs_a, exp);
      end
      if (i == 1) begin
        if_a.load_valid  = 1'b1;
        if_a.parallel_in = 4'b0011;
      end
      tick();
      if_a.load_valid = 1'b0;
    end
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL busy_load done: got %b want %b", obs_a, 5'b00011);
    end
    tick();
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL busy_load idle: got %b want %b", obs_a, 5'b00010);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] seq;
    logic [4:0] exp;
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1111;
    tick();
    if_a.load_valid  = 1'b0;
    checks++;
    if (obs_a !== 5'b11000) begin
      errors++;
      $display("FAIL mid_reset bit0: got %b want %b", obs_a, 5'b11000);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL mid_reset after: got %b want %b", obs_a, 5'b00010);
    end
    tick();
    checks++;
    if (obs_a !== 5'b00010) begin
      errors++;
      $display("FAIL mid_reset no_done: got %b want %b", obs_a, 5'b00010);
    end
    seq = 4'b1010;
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1010;
    tick();
    if_a.load_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, seq[3-i], (i == 3), (i == 3), 1'b0};
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL mid_reset reload bit%0d: got %b want %b", i, obs_a, exp);
      end
      tick();
    end
    checks++;
    if (obs_a !== 5'b00011) begin
      errors++;
      $display("FAIL mid_reset reload done: got %b want %b", obs_a, 5'b00011);
    end
    tick();
  endtask

  task automatic test_loopback();
    if_a.load_valid  = 1'b1;
    if_a.parallel_in = 4'b1011;
    tick();
    if_a.load_valid  = 1'b0;
    if_a.parallel_in = 4'b0000;
    // First bit is now on serial_out; four edges shift the whole word into the receiver.
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sipo_q !== 4'b1011) begin
      errors++;
      $display("FAIL loopback: got %b want %b", sipo_q, 4'b1011);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    if_a.load_valid  = 1'b0;
    if_a.parallel_in = '0;
    if_b.load_valid  = 1'b0;
    if_b.parallel_in = '0;
    @(negedge clk);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_busy_load();
    test_reset_mid_word();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
